// File: rtl/capture_sequencer.sv
// Photon-counting capture sequencer: integrates photon strobes per DMD pattern window, stores counts, then streams them out.
// Optional build macro COUNT_SATURATE_EN: counts hold at full scale instead of wrapping.
module capture_sequencer #(
  parameter int unsigned NUM_PATTERNS = 1024,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              clk,
  input  logic              RD,
  input  logic              start,
  input  logic              dmd_sig,
  input  logic              photon_pulse,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PATTERNS - 1);
  localparam logic [DATA_W-1:0] COUNT_MAX = {DATA_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, WAIT_DMD, INTEGRATE, WRITE, READ_REQ, READ_WAIT, SEND
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              dmd_q;
  logic              mem_we_d, tx_valid_d, busy_d, done_d, overflow_d;
  logic [DATA_W-1:0] mem_wdata_d, tx_data_d;
  logic              dmd_rise, dmd_fall;

  assign dmd_rise = dmd_sig & ~dmd_q;
  assign dmd_fall = ~dmd_sig & dmd_q;
  assign mem_addr = index_q;

  // State and all registered outputs
  always_ff @(posedge clk or posedge RD) begin
    if (RD) begin
      state_q   <= IDLE;
      index_q   <= '0;
      count_q   <= '0;
      dmd_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      count_q   <= count_d;
      dmd_q     <= dmd_sig;
      mem_we    <= mem_we_d;
      mem_wdata <= mem_wdata_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      overflow  <= overflow_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    count_d    = count_q;
    tx_data_d  = tx_data;
    overflow_d = overflow;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT_DMD;
          index_d    = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      WAIT_DMD: begin
        if (dmd_rise) begin
          state_d = INTEGRATE;
          count_d = DATA_W'(photon_pulse);
        end
      end
      INTEGRATE: begin
        // The falling-edge cycle has dmd_sig low, so its photon is never counted
        if (dmd_fall) begin
          state_d = WRITE;
        end else if (dmd_sig && photon_pulse) begin
          if (count_q == COUNT_MAX) begin
            overflow_d = 1'b1;
`ifdef COUNT_SATURATE_EN
            count_d    = COUNT_MAX;
`else
            count_d    = '0;
`endif
          end else begin
            count_d = count_q + DATA_W'(1);
          end
        end
      end
      WRITE: begin
        if (index_q == LAST_IDX) begin
          state_d = READ_REQ;
          index_d = '0;
        end else begin
          state_d = WAIT_DMD;
          index_d = index_q + ADDR_W'(1);
        end
      end
      READ_REQ: begin
        state_d = READ_WAIT;
      end
      READ_WAIT: begin
        tx_data_d = mem_rdata;
        state_d   = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = READ_REQ;
            index_d = index_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
        count_d = '0;
      end
    endcase

    // Outputs follow the state being entered so they are valid for its whole duration
    mem_we_d    = (state_d == WRITE);
    mem_wdata_d = (state_d == WRITE) ? count_d : '0;
    tx_valid_d  = (state_d == SEND);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer with a 4-pattern acquisition and a behavioural 1-cycle-latency memory.
module tb_capture_sequencer;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          RD = 1'b1;
  logic          start = 1'b0;
  logic          dmd_sig = 1'b0;
  logic          photon_pulse = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;
  logic          overflow;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_tx[$];
  logic [DW-1:0] mem [NP];
  int            n_vec = 0;
  int            n_bad = 0;
  int            done_cnt = 0;

  capture_sequencer #(.NUM_PATTERNS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .RD(RD), .start(start), .dmd_sig(dmd_sig), .photon_pulse(photon_pulse),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic window(input int photons, input bit ph_rise, input bit ph_fall);
    dmd_sig = 1'b1; photon_pulse = ph_rise; step(1);
    photon_pulse = 1'b1; step(photons);
    dmd_sig = 1'b0; photon_pulse = ph_fall; step(1);
    photon_pulse = 1'b0; step(2);
  endtask

  task automatic push_acq(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                          input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    logic [DW-1:0] c [NP];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < NP; i++) begin
      exp_wr.push_back('{addr: AW'(i), data: c[i]});
      exp_tx.push_back(c[i]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk(name, 32'(busy), 0);
    @(negedge clk);
    step(1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_we"}, 32'(mem_we), 0);
    chk({name, "_addr"}, 32'(mem_addr), 0);
    chk({name, "_wdata"}, 32'(mem_wdata), 0);
    chk({name, "_txdata"}, 32'(tx_data), 0);
    chk({name, "_txvalid"}, 32'(tx_valid), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    wr_t w;
    logic [DW-1:0] t;
    logic [DW-1:0] big_exp;

    // Monitor: pops the scoreboard on every write strobe and every tx transfer
    fork
      forever begin
        @(negedge clk);
        if (!RD) begin
          if (mem_we) begin
            if (exp_wr.size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL unexpected_write: addr %0d data %0d at %0t", mem_addr, mem_wdata, $time);
            end else begin
              w = exp_wr.pop_front();
              chk("wr_addr", 32'(mem_addr), 32'(w.addr));
              chk("wr_data", 32'(mem_wdata), 32'(w.data));
            end
          end else begin
            chk("wdata_idle", 32'(mem_wdata), 0);
          end
          if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL unexpected_tx: data %0d at %0t", tx_data, $time);
            end else begin
              t = exp_tx.pop_front();
              chk("tx_data", 32'(tx_data), 32'(t));
            end
          end
          if (done) done_cnt++;
        end
      end
    join_none

    // Reset state
    step(3);
    @(negedge clk);
    check_reset_outputs("reset");
    step(1);
    RD = 1'b0;
    step(2);

    // Basic acquisition 3,0,7,1; pattern 2 has photons on both the rise and fall cycles
    push_acq(16'd3, 16'd0, 16'd7, 16'd1);
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 1);
    step(1);
    window(3, 1'b0, 1'b0);
    window(0, 1'b0, 1'b0);
    window(6, 1'b1, 1'b1);
    window(1, 1'b0, 1'b0);
    wait_idle("acq1_idle");
    chk("acq1_done", 32'(done_cnt), 1);
    chk("acq1_ovf", 32'(overflow), 0);

    // Backpressure during SEND with a stray start that must be ignored
    tx_ready = 1'b0;
    push_acq(16'd5, 16'd2, 16'd9, 16'd4);
    pulse_start();
    window(5, 1'b0, 1'b0);
    window(2, 1'b0, 1'b0);
    window(9, 1'b0, 1'b0);
    window(4, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        @(posedge clk); #1;
        start = 1'b1;
      end else begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid", 32'(tx_valid), 1);
      chk("bp_data", 32'(tx_data), 5);
      chk("bp_addr", 32'(mem_addr), 0);
    end
    step(1);
    start = 1'b0;
    tx_ready = 1'b1;
    wait_idle("acq2_idle");
    chk("acq2_done", 32'(done_cnt), 2);

    // Overflow: 70000 photons in pattern 0
`ifdef COUNT_SATURATE_EN
    big_exp = 16'hFFFF;
`else
    big_exp = 16'd4464;
`endif
    push_acq(big_exp, 16'd0, 16'd0, 16'd0);
    pulse_start();
    window(70000, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    step(1);
    window(0, 1'b0, 1'b0);
    window(0, 1'b0, 1'b0);
    window(0, 1'b0, 1'b0);
    wait_idle("acq3_idle");
    chk("ovf_sticky", 32'(overflow), 1);
    chk("acq3_done", 32'(done_cnt), 3);

    // Reset during INTEGRATE of pattern 2
    exp_wr.push_back('{addr: AW'(0), data: 16'd2});
    exp_wr.push_back('{addr: AW'(1), data: 16'd1});
    pulse_start();
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 0);
    step(1);
    window(2, 1'b0, 1'b0);
    window(1, 1'b0, 1'b0);
    dmd_sig = 1'b1; photon_pulse = 1'b1;
    step(3);
    RD = 1'b1;
    #1;
    check_reset_outputs("midreset");
    dmd_sig = 1'b0; photon_pulse = 1'b0;
    step(2);
    RD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_busy", 32'(busy), 0);
      chk("post_reset_we", 32'(mem_we), 0);
    end
    step(1);

    // Recovery after reset
    push_acq(16'd1, 16'd2, 16'd3, 16'd4);
    pulse_start();
    window(1, 1'b0, 1'b0);
    window(2, 1'b0, 1'b0);
    window(3, 1'b0, 1'b0);
    window(4, 1'b0, 1'b0);
    wait_idle("acq5_idle");
    chk("acq5_done", 32'(done_cnt), 4);
    chk("wr_queue_empty", 32'(exp_wr.size()), 0);
    chk("tx_queue_empty", 32'(exp_tx.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
